// File: rtl/bus_trace_buffer.sv
// rtl/bus_trace_buffer.sv - ring-buffer bus trace capture with address/type trigger and indexed readout
// Optional build macro TRACE_QUAL_EN adds sync-only qualification and a per-entry timestamp.
module bus_trace_buffer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 10,
    parameter int TS_W       = 16,
`ifdef TRACE_QUAL_EN
    localparam int ENTRY_W   = 2 + ADDR_W + DATA_W + TS_W
`else
    localparam int ENTRY_W   = 2 + ADDR_W + DATA_W
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic [ADDR_W-1:0]       bus_addr,
    input  logic [DATA_W-1:0]       bus_data,
    input  logic                    bus_rnw,
    input  logic                    bus_sync,
`ifdef TRACE_QUAL_EN
    input  logic                    qual_sync_only,
`endif
    input  logic                    arm,
    input  logic                    force_trig,
    input  logic [ADDR_W-1:0]       trig_addr,
    input  logic [ADDR_W-1:0]       trig_mask,
    input  logic [1:0]              trig_type,
    input  logic [DEPTH_LOG2-1:0]   post_count,
    output logic [1:0]              state,
    output logic                    wrapped,
    output logic [DEPTH_LOG2:0]     count,
    output logic [DEPTH_LOG2-1:0]   trig_index,
    input  logic                    rd_en,
    input  logic [DEPTH_LOG2-1:0]   rd_index,
    output logic [ENTRY_W-1:0]      rd_data,
    output logic                    rd_valid
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t                  state_q, state_next;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   trig_slot;
    logic [DEPTH_LOG2-1:0]   remaining;
    logic                    force_pend;
    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [ENTRY_W-1:0]      wr_entry;
    logic                    qual_ok, type_ok, addr_ok;
    logic                    capture, trigger;
    logic [DEPTH_LOG2-1:0]   base;

`ifdef TRACE_QUAL_EN
    logic [TS_W-1:0]         ts;

    assign qual_ok  = !qual_sync_only || bus_sync;
    assign wr_entry = {ts, bus_sync, bus_rnw, bus_addr, bus_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ts <= '0;
        else if (arm)
            ts <= '0;
        else if (clken)
            ts <= ts + 1'b1;
    end
`else
    assign qual_ok  = 1'b1;
    assign wr_entry = {bus_sync, bus_rnw, bus_addr, bus_data};
`endif

    always_comb begin
        type_ok = 1'b1;
        case (trig_type)
            2'b01:   type_ok = bus_rnw;
            2'b10:   type_ok = !bus_rnw;
            2'b11:   type_ok = bus_sync && bus_rnw;
            default: type_ok = 1'b1;
        endcase
    end

    assign addr_ok = ((bus_addr ^ trig_addr) & trig_mask) == '0;
    // A clken arriving together with arm belongs to the old capture and is dropped.
    assign capture = clken && !arm && qual_ok && (state_q == ST_ARMED || state_q == ST_POST);
    assign trigger = capture && (state_q == ST_ARMED) &&
                     ((addr_ok && type_ok) || force_pend || force_trig);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_next;
    end

    // post_count is DEPTH_LOG2 bits wide, so it can never exceed DEPTH-1 and the
    // trigger entry is never overwritten during POST.
    always_comb begin
        state_next = state_q;
        if (arm)
            state_next = ST_ARMED;
        else begin
            case (state_q)
                ST_ARMED: if (trigger) state_next = (post_count == '0) ? ST_DONE : ST_POST;
                ST_POST:  if (capture && remaining == 1) state_next = ST_DONE;
                default:  state_next = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            wrapped    <= 1'b0;
            trig_slot  <= '0;
            remaining  <= '0;
            force_pend <= 1'b0;
        end else if (arm) begin
            wr_ptr     <= '0;
            wrapped    <= 1'b0;
            force_pend <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == DEPTH_LOG2'(DEPTH - 1))
                    wrapped <= 1'b1;
            end
            if (trigger) begin
                trig_slot <= wr_ptr;
                remaining <= post_count;
            end else if (capture && state_q == ST_POST)
                remaining <= remaining - 1'b1;
            if (state_q != ST_ARMED || capture)
                force_pend <= 1'b0;
            else if (force_trig)
                force_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            mem[wr_ptr] <= wr_entry;
    end

    assign base = wrapped ? wr_ptr : '0;

    // Read port sees the pre-write RAM value when it hits the slot being captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= mem[base + rd_index];
        end
    end

    assign state      = state_q;
    assign count      = wrapped ? (DEPTH_LOG2 + 1)'(DEPTH) : {1'b0, wr_ptr};
    assign trig_index = trig_slot - base;
endmodule

// File: tb/tb_bus_trace_buffer.sv
// tb/tb_bus_trace_buffer.sv - directed self-checking bench for bus_trace_buffer at DEPTH_LOG2=4
module tb_bus_trace_buffer;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int DL2    = 4;
    localparam int EW     = 2 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clken = 1'b0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic [DATA_W-1:0] bus_data = '0;
    logic              bus_rnw = 1'b1;
    logic              bus_sync = 1'b0;
`ifdef TRACE_QUAL_EN
    logic              qual_sync_only = 1'b0;
`endif
    logic              arm = 1'b0;
    logic              force_trig = 1'b0;
    logic [ADDR_W-1:0] trig_addr = 16'hFFFF;
    logic [ADDR_W-1:0] trig_mask = 16'hFFFF;
    logic [1:0]        trig_type = 2'b00;
    logic [DL2-1:0]    post_count = 4'd3;
    logic [1:0]        state;
    logic              wrapped;
    logic [DL2:0]      count;
    logic [DL2-1:0]    trig_index;
    logic              rd_en = 1'b0;
    logic [DL2-1:0]    rd_index = '0;
    logic [EW-1:0]     rd_data;
    logic              rd_valid;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] rd_word;

    bus_trace_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DL2), .TS_W(16)) dut (
        .clk(clk), .reset(reset), .clken(clken),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_rnw(bus_rnw), .bus_sync(bus_sync),
`ifdef TRACE_QUAL_EN
        .qual_sync_only(qual_sync_only),
`endif
        .arm(arm), .force_trig(force_trig),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_type(trig_type),
        .post_count(post_count),
        .state(state), .wrapped(wrapped), .count(count), .trig_index(trig_index),
        .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dat(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic cyc(input logic [15:0] a, input logic rnw);
        clken = 1'b1; bus_addr = a; bus_data = dat(a); bus_rnw = rnw;
        @(posedge clk); #1;
        clken = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic pulse_force();
        force_trig = 1'b1;
        @(posedge clk); #1;
        force_trig = 1'b0;
    endtask

    task automatic rd(input logic [DL2-1:0] idx, output logic [EW-1:0] d);
        rd_en = 1'b1; rd_index = idx;
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'd1);
        d = rd_data;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        chk("rst_trig_index", 32'(trig_index), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: five reads, no trigger
        pulse_arm();
        chk("t1_armed", 32'(state), 32'd1);
        for (int i = 0; i < 5; i++) cyc(16'h0100 + 16'(i), 1'b1);
        chk("t1_state", 32'(state), 32'd1);
        chk("t1_count", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) begin
            rd(DL2'(i), rd_word);
            chk("t1_entry", 32'(rd_word), 32'({1'b0, 1'b1, 16'h0100 + 16'(i), dat(16'h0100 + 16'(i))}));
        end
        @(posedge clk); #1;
        chk("t1_rd_valid_drop", 32'(rd_valid), 32'd0);

        // 2: wrap without trigger
        pulse_arm();
        chk("t2_count_cleared", 32'(count), 32'd0);
        for (int i = 0; i < 20; i++) cyc(16'(i), 1'b1);
        chk("t2_wrapped", 32'(wrapped), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        rd(4'd0, rd_word);
        chk("t2_oldest", 32'(rd_word[23:8]), 32'd4);
        rd(4'd15, rd_word);
        chk("t2_newest", 32'(rd_word[23:8]), 32'd19);

        // 3: address trigger with post_count=3
        trig_addr = 16'h0007; post_count = 4'd3;
        pulse_arm();
        for (int i = 0; i <= 20; i++) begin
            cyc(16'(i), 1'b1);
            if (i == 7) chk("t3_post", 32'(state), 32'd2);
            if (i == 10) chk("t3_done_at_10", 32'(state), 32'd3);
        end
        chk("t3_state", 32'(state), 32'd3);
        chk("t3_count", 32'(count), 32'd11);
        chk("t3_trig_index", 32'(trig_index), 32'd7);
        rd(4'd10, rd_word);
        chk("t3_last_entry", 32'(rd_word[23:8]), 32'd10);

        // 4: write-only trigger type, post_count=0
        trig_type = 2'b10; post_count = 4'd0;
        pulse_arm();
        cyc(16'h0007, 1'b1);
        chk("t4_read_ignored", 32'(state), 32'd1);
        cyc(16'h0007, 1'b0);
        chk("t4_done", 32'(state), 32'd3);
        chk("t4_trig_index", 32'(trig_index), 32'd1);
        chk("t4_count", 32'(count), 32'd2);
        rd(trig_index, rd_word);
        chk("t4_rnw", 32'(rd_word[24]), 32'd0);

        // 5a: force_trig pending until next clken, post_count=0
        trig_type = 2'b00; trig_addr = 16'hFFFF;
        pulse_arm();
        pulse_force();
        chk("t5_force_pending", 32'(state), 32'd1);
        cyc(16'h0020, 1'b1);
        chk("t5_done", 32'(state), 32'd3);
        chk("t5_count", 32'(count), 32'd1);
        chk("t5_trig_index", 32'(trig_index), 32'd0);

        // 5b: maximum post_count fills buffer exactly, trigger entry survives
        post_count = 4'd15;
        pulse_arm();
        pulse_force();
        for (int i = 0; i < 16; i++) begin
            cyc(16'h0030 + 16'(i), 1'b1);
            if (i == 14) chk("t5b_still_post", 32'(state), 32'd2);
        end
        chk("t5b_done", 32'(state), 32'd3);
        chk("t5b_wrapped", 32'(wrapped), 32'd1);
        chk("t5b_trig_index", 32'(trig_index), 32'd0);
        rd(4'd0, rd_word);
        chk("t5b_trig_entry", 32'(rd_word[23:8]), 32'h0030);

        // 6: clken with arm is dropped; mask=0 matches any; re-arm mid-POST; async reset
        trig_mask = 16'h0000;
        arm = 1'b1; clken = 1'b1; bus_addr = 16'h0999;
        @(posedge clk); #1;
        arm = 1'b0; clken = 1'b0;
        chk("t6_arm_clken_count", 32'(count), 32'd0);
        chk("t6_arm_clken_state", 32'(state), 32'd1);
        cyc(16'h0040, 1'b1);
        chk("t6_mask0_post", 32'(state), 32'd2);
        cyc(16'h0041, 1'b1);
        cyc(16'h0042, 1'b1);
        pulse_arm();
        chk("t6_rearm_state", 32'(state), 32'd1);
        chk("t6_rearm_count", 32'(count), 32'd0);
        chk("t6_rearm_wrapped", 32'(wrapped), 32'd0);
        cyc(16'h0050, 1'b1);
        cyc(16'h0051, 1'b1);
        chk("t6_post_again", 32'(state), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_state", 32'(state), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
